// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative array multiplier.
// Holds the control FSM encoding and the RUN-cycle count helper.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles needed to sweep every multiplier bit.
    function automatic int calc_n(input int width, input int rows_per_cycle);
        return width / rows_per_cycle;
    endfunction

endpackage

// File: rtl/mul_iter_array_if.sv
// Operand/result handshake bundle for mul_iter_array.
// master = producer/consumer side, slave = the multiplier.
interface mul_iter_array_if #(
    parameter int WIDTH = 64
);
    import mul_pkg::*;

    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // valid may not depend combinationally on ready, and flush overrides both.
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     srca;
    logic [WIDTH-1:0]     srcb;
    logic                 sign_a;
    logic                 sign_b;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output in_valid, srca, srcb, sign_a, sign_b, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, srca, srcb, sign_a, sign_b, flush, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/mul_row_adder.sv
// Combinational step of the array multiplier: folds ROWS_PER_CYCLE shifted
// AND partial-product rows into the running accumulator.
module mul_row_adder
    import mul_pkg::*;
#(
    parameter int WIDTH          = 64,
    parameter int ROWS_PER_CYCLE = 4
) (
    input  logic [2*WIDTH-1:0]           acc,
    input  logic [WIDTH-1:0]             mag_a,
    input  logic [ROWS_PER_CYCLE-1:0]    b_slice,
    input  logic [$clog2(WIDTH+1)-1:0]   row_idx,
    output logic [2*WIDTH-1:0]           acc_next
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    always_comb begin
        acc_next = acc;
        for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
            acc_next = acc_next +
                ({{WIDTH{1'b0}}, mag_a & {WIDTH{b_slice[j]}}} << (row_idx + CNT_W'(j)));
        end
    end

endmodule

// File: rtl/mul_iter_array.sv
// Iterative signed/unsigned multiplier: sign-magnitude operands, WIDTH/ROWS_PER_CYCLE
// accumulate cycles, then the product is held until the consumer takes it.
module mul_iter_array
    import mul_pkg::*;
#(
    parameter int WIDTH          = 64,
    parameter int ROWS_PER_CYCLE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mul_iter_array_if.slave       bus,
    output state_t                dbg_state
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int N     = calc_n(WIDTH, ROWS_PER_CYCLE);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'((N - 1) * ROWS_PER_CYCLE);
    localparam logic [CNT_W-1:0] ROW_STEP = CNT_W'(ROWS_PER_CYCLE);

    if (WIDTH < 4 || ROWS_PER_CYCLE < 1 || (WIDTH % ROWS_PER_CYCLE) != 0) begin : g_bad_params
        $error("mul_iter_array: ROWS_PER_CYCLE must divide WIDTH and WIDTH must be >= 4");
    end

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [CNT_W-1:0]     row_cnt;
    logic [2*WIDTH-1:0]   result_q;
    logic                 a_neg;
    logic                 b_neg;
    logic                 last_row;

    // Negating -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign a_neg    = bus.sign_a & bus.srca[WIDTH-1];
    assign b_neg    = bus.sign_b & bus.srcb[WIDTH-1];
    assign last_row = (row_cnt == LAST_ROW);

    mul_row_adder #(
        .WIDTH          (WIDTH),
        .ROWS_PER_CYCLE (ROWS_PER_CYCLE)
    ) u_row_adder (
        .acc      (acc),
        .mag_a    (mag_a),
        .b_slice  (mag_b[row_cnt +: ROWS_PER_CYCLE]),
        .row_idx  (row_cnt),
        .acc_next (acc_next)
    );

    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.in_valid)  state_next = RUN;
                RUN:     if (last_row)      state_next = DONE;
                DONE:    if (bus.out_ready) state_next = IDLE;
                default:                    state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mag_a    <= '0;
            mag_b    <= '0;
            neg      <= 1'b0;
            acc      <= '0;
            row_cnt  <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            if (!bus.flush) begin
                if (state == IDLE && bus.in_valid) begin
                    mag_a   <= a_neg ? -bus.srca : bus.srca;
                    mag_b   <= b_neg ? -bus.srcb : bus.srcb;
                    neg     <= a_neg ^ b_neg;
                    acc     <= '0;
                    row_cnt <= '0;
                end else if (state == RUN) begin
                    acc     <= acc_next;
                    row_cnt <= row_cnt + ROW_STEP;
                    if (last_row) begin
                        result_q <= neg ? -acc_next : acc_next;
                    end
                end
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_mul_iter_array.sv
// Directed bench for mul_iter_array at WIDTH=8, ROWS_PER_CYCLE=2 (4 RUN cycles).
// Expected products are hand-computed and pushed to a queue consumed by a monitor.
module tb_mul_iter_array;
    import mul_pkg::*;

    localparam int WIDTH = 8;
    localparam int RPC   = 2;
    localparam int RW    = 2 * WIDTH;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    mul_iter_array_if #(.WIDTH(WIDTH)) bus ();

    mul_iter_array #(
        .WIDTH          (WIDTH),
        .ROWS_PER_CYCLE (RPC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    logic [RW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every completed output transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                check("result", 64'(bus.result), 64'(exp_q.pop_front()));
            end
        end
    end

    // Drivers
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sa, input logic sb);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_before_issue", 64'(bus.in_ready), 64'd1);
        bus.srca     = a;
        bus.srcb     = b;
        bus.sign_a   = sa;
        bus.sign_b   = sb;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check(name, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic run_product(input string name, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic sa, input logic sb,
                               input logic [RW-1:0] exp);
        exp_q.push_back(exp);
        issue(a, b, sa, sb);
        wait_valid(name);
        tick();
    endtask

    initial begin
        int lat;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.srca      = '0;
        bus.srcb      = '0;
        bus.sign_a    = 1'b0;
        bus.sign_b    = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        tick(2);
        rst = 1'b0;

        check("reset_in_ready",  64'(bus.in_ready),  64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result",    64'(bus.result),    64'd0);
        check("reset_state",     64'(dbg_state),     64'(IDLE));

        // Unsigned 13 x 11 with latency counted from the accepting edge inclusive
        exp_q.push_back(16'h008F);
        bus.srca = 8'd13; bus.srcb = 8'd11; bus.sign_a = 1'b0; bus.sign_b = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'd5);
        tick();

        // Signed and mixed-sign corners
        run_product("valid_m3x5",     8'hFD, 8'h05, 1'b1, 1'b1, 16'hFFF1);
        run_product("valid_80x80_s",  8'h80, 8'h80, 1'b1, 1'b1, 16'h4000);
        run_product("valid_ffxff_u",  8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01);
        run_product("valid_ffs_ffu",  8'hFF, 8'hFF, 1'b1, 1'b0, 16'hFF01);
        run_product("valid_80u_x2",   8'h80, 8'h02, 1'b0, 1'b1, 16'h0100);

        // Backpressure: hold DONE for 10 cycles while a new pair is offered
        bus.out_ready = 1'b0;
        exp_q.push_back(16'h0258);
        issue(8'd200, 8'd3, 1'b0, 1'b0);
        wait_valid("valid_bp");
        bus.srca = 8'd1; bus.srcb = 8'd1; bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_result",    64'(bus.result),    64'h0258);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_after_in_ready",  64'(bus.in_ready),  64'd1);
        check("bp_after_out_valid", 64'(bus.out_valid), 64'd0);

        // Flush on the 2nd RUN cycle, then an immediate new pair
        issue(8'd100, 8'd100, 1'b0, 1'b0);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_state",     64'(dbg_state),     64'(IDLE));
        check("flush_in_ready",  64'(bus.in_ready),  64'd1);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        run_product("valid_7x9", 8'd7, 8'd9, 1'b0, 1'b0, 16'h003F);

        // Reset mid-RUN
        issue(8'd50, 8'd50, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_run_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_run_result",    64'(bus.result),    64'd0);
        check("rst_run_state",     64'(dbg_state),     64'(IDLE));

        // Reset together with flush while in DONE
        bus.out_ready = 1'b0;
        issue(8'd13, 8'd11, 1'b0, 1'b0);
        wait_valid("valid_pre_rst_done");
        check("pre_rst_done_result", 64'(bus.result), 64'h008F);
        rst = 1'b1;
        bus.flush = 1'b1;
        tick();
        rst = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        check("rst_done_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_done_result",    64'(bus.result),    64'd0);
        check("rst_done_in_ready",  64'(bus.in_ready),  64'd1);

        // Recovery after reset
        run_product("valid_post_rst", 8'hF9, 8'h09, 1'b1, 1'b0, 16'hFFC1);

        tick(3);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
